// File: rtl/shutdown_fault_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : shutdown_fault_monitor_if
// Description : Signal bundle between the shutdown fault monitor and its
//               surroundings: the system-side control and status, and the
//               scanner-side sense vector and enable.
//   master : the monitor. It consumes enable, fault_mask, shutdown_sense and
//            clear_req. It drives shutdown_sense_en, clear_ack, armed,
//            shutdown_force, fault_status, first_fault, trip_count and state.
//   slave  : the system/scanner side, with the opposite directions.
// Revision    : 1.0 - initial release
// ============================================================================
interface shutdown_fault_monitor_if;
    logic       enable;
    logic [7:0] fault_mask;
    logic [7:0] shutdown_sense;
    logic       shutdown_sense_en;
    logic       clear_req;
    logic       clear_ack;
    logic       armed;
    logic       shutdown_force;
    logic [7:0] fault_status;
    logic [2:0] first_fault;
    logic [7:0] trip_count;
    logic [2:0] state;

    modport master (
        input  enable, fault_mask, shutdown_sense, clear_req,
        output shutdown_sense_en, clear_ack, armed, shutdown_force,
               fault_status, first_fault, trip_count, state
    );

    modport slave (
        output enable, fault_mask, shutdown_sense, clear_req,
        input  shutdown_sense_en, clear_ack, armed, shutdown_force,
               fault_status, first_fault, trip_count, state
    );
endinterface
`default_nettype wire

// File: rtl/shutdown_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module      : shutdown_fault_monitor
// Description : Qualifies the sticky shutdown sense vector from the scanner
//               against a live mask. It latches the first trip into a
//               registered shutdown_force and records which channels faulted.
//               A trip is released only through a clear handshake, which
//               holds the scanner enable low to wipe its sticky bits.
// Ports       : clk            - system clock, rising edge
//               aresetn        - asynchronous active-low reset
//               bus (master)   - enable, fault_mask, shutdown_sense,
//                                clear_req in; shutdown_sense_en, clear_ack,
//                                armed, shutdown_force, fault_status,
//                                first_fault, trip_count, state out
// Revision    : 1.0 - initial release
// ============================================================================
module shutdown_fault_monitor #(
    parameter int ARM_CYCLES = 16,
    parameter int CLEAR_HOLD = 2
) (
    input  wire logic                clk,
    input  wire logic                aresetn,
    shutdown_fault_monitor_if.master bus
);

    typedef enum logic [2:0] {
        S_DISABLED = 3'd0,
        S_ARMING   = 3'd1,
        S_ARMED    = 3'd2,
        S_TRIPPED  = 3'd3,
        S_CLEARING = 3'd4
    } state_t;

    // The arm and clear phases never overlap, so one counter serves both.
    localparam int c_CNT_MAX = (ARM_CYCLES > CLEAR_HOLD) ? ARM_CYCLES : CLEAR_HOLD;
    localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_ARM_LAST = c_CNT_W'(ARM_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CLR_LAST = c_CNT_W'(CLEAR_HOLD - 1);

    generate
        if (ARM_CYCLES < 9) begin : g_arm_check
            $error("ARM_CYCLES must cover 8 mux positions plus a register stage");
        end
        if (CLEAR_HOLD < 1) begin : g_clear_check
            $error("CLEAR_HOLD must be at least 1");
        end
    endgenerate

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sense_en;
    logic               r_clear_ack;
    logic               r_armed;
    logic               r_force;
    logic [7:0]         r_status;
    logic [2:0]         r_first;
    logic [7:0]         r_trip_count;

    logic [7:0]         w_unmasked;
    logic               w_trip;
    logic [2:0]         w_lowest;

    assign w_unmasked = bus.shutdown_sense & ~bus.fault_mask;
    assign w_trip     = (w_unmasked != 8'h00);

    // Scan from the top down so the last hit is the lowest set channel.
    always_comb begin
        w_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_unmasked[i]) begin
                w_lowest = 3'(i);
            end
        end
    end

    // Every output is loaded together with the state it belongs to, so each
    // one is a flop and changes on the same edge as the state.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_DISABLED;
            r_cnt        <= '0;
            r_sense_en   <= 1'b0;
            r_clear_ack  <= 1'b0;
            r_armed      <= 1'b0;
            r_force      <= 1'b0;
            r_status     <= 8'h00;
            r_first      <= 3'd0;
            r_trip_count <= 8'h00;
        end else begin
            r_clear_ack <= 1'b0;

            // A trip is checked ahead of the state case. This gives it
            // priority over enable dropping in both monitoring states.
            if ((r_state == S_ARMING || r_state == S_ARMED) && w_trip) begin
                r_state  <= S_TRIPPED;
                r_force  <= 1'b1;
                r_armed  <= 1'b0;
                r_status <= w_unmasked;
                r_first  <= w_lowest;
                if (r_trip_count != 8'hFF) begin
                    r_trip_count <= r_trip_count + 8'd1;
                end
            end else begin
                case (r_state)
                    S_DISABLED: begin
                        if (bus.enable) begin
                            r_state    <= S_ARMING;
                            r_cnt      <= '0;
                            r_sense_en <= 1'b1;
                        end
                    end

                    S_ARMING: begin
                        if (!bus.enable) begin
                            r_state    <= S_DISABLED;
                            r_sense_en <= 1'b0;
                        end else if (r_cnt == c_ARM_LAST) begin
                            r_state <= S_ARMED;
                            r_armed <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    S_ARMED: begin
                        if (!bus.enable) begin
                            r_state    <= S_DISABLED;
                            r_sense_en <= 1'b0;
                            r_armed    <= 1'b0;
                        end
                    end

                    S_TRIPPED: begin
                        // Keep collecting faults, including channels that were
                        // unmasked after the trip; first_fault stays frozen.
                        r_status <= r_status | w_unmasked;
                        if (bus.clear_req) begin
                            r_state    <= S_CLEARING;
                            r_cnt      <= '0;
                            r_sense_en <= 1'b0;
                        end
                    end

                    S_CLEARING: begin
                        if (r_cnt == c_CLR_LAST) begin
                            r_clear_ack <= 1'b1;
                            r_status    <= 8'h00;
                            r_first     <= 3'd0;
                            r_force     <= 1'b0;
                            r_cnt       <= '0;
                            if (bus.enable) begin
                                r_state    <= S_ARMING;
                                r_sense_en <= 1'b1;
                            end else begin
                                r_state    <= S_DISABLED;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    default: begin
                        r_state    <= S_DISABLED;
                        r_cnt      <= '0;
                        r_sense_en <= 1'b0;
                        r_armed    <= 1'b0;
                        r_force    <= 1'b0;
                        r_status   <= 8'h00;
                        r_first    <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign bus.shutdown_sense_en = r_sense_en;
    assign bus.clear_ack         = r_clear_ack;
    assign bus.armed             = r_armed;
    assign bus.shutdown_force    = r_force;
    assign bus.fault_status      = r_status;
    assign bus.first_fault       = r_first;
    assign bus.trip_count        = r_trip_count;
    assign bus.state             = r_state;

endmodule
`default_nettype wire

// File: tb/tb_shutdown_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_shutdown_fault_monitor
// Description : Self-checking bench for shutdown_fault_monitor. It runs a
//               directed vector table, hand-written saturation and
//               reset-during-clear sequences, and a randomized run that is
//               compared against a behavioural model. The random run drives
//               a sticky scanner stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shutdown_fault_monitor;
    localparam int c_ARM  = 16;
    localparam int c_HOLD = 2;

    logic clk     = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    shutdown_fault_monitor_if bus ();

    shutdown_fault_monitor #(
        .ARM_CYCLES (c_ARM),
        .CLEAR_HOLD (c_HOLD)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus.master)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int st, input int sen,
                                 input int arm, input int frc, input int ack,
                                 input int stat, input int first, input int cnt);
        chk({tag, " state"},          int'(bus.state),             st);
        chk({tag, " sense_en"},       int'(bus.shutdown_sense_en), sen);
        chk({tag, " armed"},          int'(bus.armed),             arm);
        chk({tag, " shutdown_force"}, int'(bus.shutdown_force),    frc);
        chk({tag, " clear_ack"},      int'(bus.clear_ack),         ack);
        chk({tag, " fault_status"},   int'(bus.fault_status),      stat);
        chk({tag, " first_fault"},    int'(bus.first_fault),       first);
        chk({tag, " trip_count"},     int'(bus.trip_count),        cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [7:0] mask,
                         input logic [7:0] sense, input logic clr);
        bus.enable         = en;
        bus.fault_mask     = mask;
        bus.shutdown_sense = sense;
        bus.clear_req      = clr;
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: inputs held for 'cyc' edges, then outputs checked.
    // ------------------------------------------------------------------
    typedef struct {
        int         cyc;
        logic       en;
        logic [7:0] mask;
        logic [7:0] sense;
        logic       clr;
        int         st, sen, arm, frc, ack, stat, first, cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int cyc, logic en, logic [7:0] mask, logic [7:0] sense,
                                logic clr, int st, int sen, int arm, int frc, int ack,
                                int stat, int first, int cnt);
        vec_t v;
        v.cyc = cyc; v.en = en; v.mask = mask; v.sense = sense; v.clr = clr;
        v.st = st; v.sen = sen; v.arm = arm; v.frc = frc; v.ack = ack;
        v.stat = stat; v.first = first; v.cnt = cnt;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: phase plus time spent in it, built from the
    // state descriptions. Phase numbers are the published status codes.
    // ------------------------------------------------------------------
    int         m_phase;
    int         m_elapsed;
    logic [7:0] m_status;
    logic [2:0] m_first;
    int         m_trips;
    int         m_ack;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_status = 8'h00; m_first = 3'd0;
        m_trips = 0; m_ack = 0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] mask,
                              input logic [7:0] sense, input logic clr);
        logic [7:0] unm;
        unm   = sense & ~mask;
        m_ack = 0;
        if ((m_phase == 1 || m_phase == 2) && unm != 8'h00) begin
            m_phase  = 3;
            m_status = unm;
            m_first  = lowest_set(unm);
            m_trips  = (m_trips < 255) ? m_trips + 1 : 255;
        end else begin
            case (m_phase)
                0: if (en) begin m_phase = 1; m_elapsed = 0; end
                1: begin
                    if (!en) m_phase = 0;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == c_ARM) m_phase = 2;
                    end
                end
                2: if (!en) m_phase = 0;
                3: begin
                    m_status = m_status | unm;
                    if (clr) begin m_phase = 4; m_elapsed = 0; end
                end
                default: begin
                    m_elapsed++;
                    if (m_elapsed == c_HOLD) begin
                        m_ack = 1; m_status = 8'h00; m_first = 3'd0;
                        m_phase = en ? 1 : 0; m_elapsed = 0;
                    end
                end
            endcase
        end
    endtask

    initial begin
        int         exp_cnt;
        logic [7:0] sticky;
        logic       r_en, r_clr;
        logic [7:0] r_mask;
        int         m_sen;

        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        aresetn = 1'b1;

        //            cyc en mask   sense  clr  st sen arm frc ack stat first cnt
        tbl.push_back(mk(1,  1, 8'h00, 8'h00, 0,  1, 1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(15, 1, 8'h00, 8'h00, 0,  1, 1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1,  1, 8'h00, 8'h00, 0,  2, 1, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1,  1, 8'h00, 8'h24, 0,  3, 1, 0, 1, 0, 8'h24, 2, 1));
        tbl.push_back(mk(1,  1, 8'h00, 8'h64, 0,  3, 1, 0, 1, 0, 8'h64, 2, 1));
        tbl.push_back(mk(3,  0, 8'h00, 8'h64, 0,  3, 1, 0, 1, 0, 8'h64, 2, 1));
        tbl.push_back(mk(1,  1, 8'h00, 8'h00, 1,  4, 0, 0, 1, 0, 8'h64, 2, 1));
        tbl.push_back(mk(1,  1, 8'h00, 8'h00, 0,  4, 0, 0, 1, 0, 8'h64, 2, 1));
        tbl.push_back(mk(1,  1, 8'h00, 8'h00, 0,  1, 1, 0, 0, 1, 8'h00, 0, 1));
        tbl.push_back(mk(1,  1, 8'h00, 8'h00, 0,  1, 1, 0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(15, 1, 8'h00, 8'h00, 0,  2, 1, 1, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(3,  1, 8'h04, 8'h04, 1,  2, 1, 1, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1,  0, 8'h00, 8'h04, 0,  3, 1, 0, 1, 0, 8'h04, 2, 2));
        tbl.push_back(mk(1,  0, 8'h00, 8'h00, 1,  4, 0, 0, 1, 0, 8'h04, 2, 2));
        tbl.push_back(mk(2,  0, 8'h00, 8'h00, 0,  0, 0, 0, 0, 1, 8'h00, 0, 2));
        tbl.push_back(mk(1,  0, 8'h00, 8'h00, 0,  0, 0, 0, 0, 0, 8'h00, 0, 2));
        tbl.push_back(mk(17, 1, 8'hFF, 8'hFF, 0,  2, 1, 1, 0, 0, 8'h00, 0, 2));
        tbl.push_back(mk(1,  1, 8'h00, 8'hFF, 0,  3, 1, 0, 1, 0, 8'hFF, 0, 3));
        tbl.push_back(mk(1,  1, 8'hFF, 8'hFF, 0,  3, 1, 0, 1, 0, 8'hFF, 0, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].mask, tbl[i].sense, tbl[i].clr);
            repeat (tbl[i].cyc) tick();
            check_outputs($sformatf("vec%0d", i), tbl[i].st, tbl[i].sen, tbl[i].arm,
                          tbl[i].frc, tbl[i].ack, tbl[i].stat, tbl[i].first, tbl[i].cnt);
        end

        // Repeated trip/clear rounds: trip_count must stop at 255.
        exp_cnt = 3;
        for (int k = 0; k < 260; k++) begin
            drive(1'b1, 8'h00, 8'h00, 1'b1);
            tick();
            drive(1'b1, 8'h00, 8'h00, 1'b0);
            repeat (c_HOLD) tick();
            drive(1'b1, 8'h00, 8'h01, 1'b0);
            tick();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            chk($sformatf("sat%0d trip_count", k), int'(bus.trip_count), exp_cnt);
        end
        chk("sat state", int'(bus.state), 3);

        // Reset in the middle of a clear drops everything without a clock edge.
        drive(1'b1, 8'h00, 8'h00, 1'b1);
        tick();
        chk("midclear state", int'(bus.state), 4);
        drive(1'b1, 8'h00, 8'h00, 1'b0);
        tick();
        #2;
        aresetn = 1'b0;
        #1;
        check_outputs("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized run against the model, with a sticky scanner stand-in.
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        model_reset();
        sticky = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            m_sen  = (m_phase >= 1 && m_phase <= 3) ? 1 : 0;
            r_en   = ($urandom_range(0, 19) != 0);
            r_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            r_clr  = ($urandom_range(0, 5) == 0);
            if (m_sen == 0) begin
                sticky = 8'h00;
            end else if ($urandom_range(0, 29) == 0) begin
                sticky = sticky | (8'h01 << $urandom_range(0, 7));
            end
            drive(r_en, r_mask, sticky, r_clr);
            @(posedge clk);
            model_step(r_en, r_mask, sticky, r_clr);
            #1;
            check_outputs($sformatf("rnd%0d", n), m_phase,
                          (m_phase >= 1 && m_phase <= 3) ? 1 : 0,
                          (m_phase == 2) ? 1 : 0,
                          (m_phase == 3 || m_phase == 4) ? 1 : 0,
                          m_ack, int'(m_status), int'(m_first), m_trips);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
